// File: rtl/tc_multi_channel.sv
// tc_multi_channel: memory-mapped bank of NUM_CH down-counting timers with sticky pending flags and masked IRQs.
// Define TC_MULTI_PRESCALER_EN to add a per-channel 8-bit prescaler in CTRL[15:8].
module tc_multi_channel #(
  parameter int          NUM_CH    = 2,
  parameter int          WIDTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       addr,
  input  logic              we,
  input  logic [3:0]        byteen,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [NUM_CH-1:0] irq
);
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CNT, ST_INT} state_t;

  logic [31:0]       offset;
  logic              in_win;
  logic [2:0]        ch_sel;
  logic [1:0]        reg_sel;
  logic [NUM_CH-1:0] ch_hit;
  logic [31:0]       ch_rdata [NUM_CH];
  logic              unused_addr;

  // Negative offsets wrap to large values, so one unsigned compare bounds both ends.
  assign offset      = {addr[31:2], 2'b00} - BASE_ADDR;
  assign in_win      = offset < 32'(16 * NUM_CH);
  assign ch_sel      = offset[6:4];
  assign reg_sel     = offset[3:2];
  assign unused_addr = ^addr[1:0];

  always_comb begin
    rdata = 32'h0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_hit[c]) rdata = rdata | ch_rdata[c];
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    state_t           state_q, state_d;
    logic             en_q, en_d, mode_q, mode_d, im_q, im_d, pend_q, pend_d;
    logic [WIDTH-1:0] preset_q, preset_d, count_q, count_d;
    logic [31:0]      preset_merge, ctrl_word, rd_word;
    logic             wr_ctrl, wr_preset, wr_status, tick;

    assign ch_hit[gi] = in_win && (ch_sel == 3'(gi));
    assign wr_ctrl    = we && ch_hit[gi] && (reg_sel == 2'd0);
    assign wr_preset  = we && ch_hit[gi] && (reg_sel == 2'd1);
    assign wr_status  = we && ch_hit[gi] && (reg_sel == 2'd3);
    assign irq[gi]    = pend_q & im_q;

`ifdef TC_MULTI_PRESCALER_EN
    logic [7:0] psc_q, psc_d, pcnt_q, pcnt_d;

    assign tick      = (pcnt_q == psc_q);
    assign ctrl_word = {16'h0, psc_q, 4'h0, im_q, 1'b0, mode_q, en_q};

    always_comb begin
      psc_d  = psc_q;
      pcnt_d = pcnt_q;
      if (wr_ctrl && byteen[1]) psc_d = wdata[15:8];
      if (!en_q || state_q == ST_LOAD) pcnt_d = 8'd0;
      else if (state_q == ST_CNT)      pcnt_d = tick ? 8'd0 : pcnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        psc_q  <= 8'd0;
        pcnt_q <= 8'd0;
      end else begin
        psc_q  <= psc_d;
        pcnt_q <= pcnt_d;
      end
    end
`else
    assign tick      = 1'b1;
    assign ctrl_word = {28'h0, im_q, 1'b0, mode_q, en_q};
`endif

    always_comb begin
      preset_merge = 32'(preset_q);
      for (int b = 0; b < 4; b++) begin
        if (byteen[b]) preset_merge[8*b +: 8] = wdata[8*b +: 8];
      end
      preset_d = wr_preset ? preset_merge[WIDTH-1:0] : preset_q;
    end

    // A CPU write to the EN byte overrides the one-shot auto-clear in the same cycle.
    always_comb begin
      en_d   = en_q;
      mode_d = mode_q;
      im_d   = im_q;
      if (state_q == ST_INT && !mode_q) en_d = 1'b0;
      if (wr_ctrl && byteen[0]) begin
        en_d   = wdata[0];
        mode_d = wdata[1];
        im_d   = wdata[3];
      end
    end

    always_comb begin
      state_d = state_q;
      count_d = count_q;
      pend_d  = pend_q;
      if (wr_status && byteen[0] && wdata[0]) pend_d = 1'b0;
      case (state_q)
        ST_IDLE: if (en_q) state_d = ST_LOAD;
        ST_LOAD: begin
          count_d = preset_q;
          state_d = ST_CNT;
        end
        ST_CNT: begin
          if (!en_q) begin
            state_d = ST_IDLE;
          end else if (tick) begin
            if (count_q <= WIDTH'(1)) begin
              count_d = '0;
              state_d = ST_INT;
            end else begin
              count_d = count_q - WIDTH'(1);
            end
          end
        end
        ST_INT: begin
          pend_d  = 1'b1;
          state_d = (mode_q && en_d) ? ST_LOAD : ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    always_comb begin
      rd_word = 32'h0;
      case (reg_sel)
        2'd0:    rd_word = ctrl_word;
        2'd1:    rd_word = 32'(preset_q);
        2'd2:    rd_word = 32'(count_q);
        default: rd_word = {31'h0, pend_q};
      endcase
    end
    assign ch_rdata[gi] = rd_word;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q  <= ST_IDLE;
        en_q     <= 1'b0;
        mode_q   <= 1'b0;
        im_q     <= 1'b0;
        pend_q   <= 1'b0;
        preset_q <= '0;
        count_q  <= '0;
      end else begin
        state_q  <= state_d;
        en_q     <= en_d;
        mode_q   <= mode_d;
        im_q     <= im_d;
        pend_q   <= pend_d;
        preset_q <= preset_d;
        count_q  <= count_d;
      end
    end
  end
endmodule
